i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
- Single-byte I2C bus master that sequences the slave block's transactions: START, 7-bit address plus R/W, ACK check, one data byte written or read, ACK/NACK, then STOP.
- Accepts one command at a time from a requester through a valid/ready handshake.
- Returns one response per command: read data and NACK status.
- Sits between the system-side requester and the open-drain SCL/SDA pads.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period; legal range 2..255. One bit slot is 4*CLK_DIV cycles.

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  requester has a command
- cmd_ready  output  1  controller can accept a command
- cmd_rw  input  1  0 = write, 1 = read; sent as the 8th address-phase bit
- cmd_addr  input  7  slave address, sent MSB first
- cmd_wdata  input  8  write byte, sent MSB first
- rsp_valid  output  1  one-cycle pulse: transaction finished
- rsp_nack  output  1  1 = address or write-data NACK seen; valid with rsp_valid
- rsp_rdata  output  8  read byte; valid with rsp_valid on reads
- busy  output  1  transaction in progress (state != IDLE)
- scl_out  output  1  SCL level driven by the master (1 = released high)
- sda_oe  output  1  1 = pull SDA low; 0 = release
- sda_in  input  1  sampled SDA line

Behaviour:
- Reset values:
  - scl_out=1, sda_oe=0, cmd_ready=0 while reset is high, then 1.
  - rsp_valid=0, rsp_nack=0, rsp_rdata=0, busy=0.
  - State=IDLE; quarter counter and bit counter = 0.
- Reset mid-transaction aborts on the next edge: bus released (scl_out=1, sda_oe=0), no STOP generated, no rsp_valid.
- Handshake:
  - cmd_ready = (state==IDLE).
  - A command is accepted on a cycle with cmd_valid && cmd_ready; cmd_rw/cmd_addr/cmd_wdata are latched then.
  - cmd_ready drops on the next cycle.
  - Inputs are ignored while busy.
- Timing base:
  - The quarter counter runs 0..CLK_DIV-1 whenever state != IDLE; tick = (count == CLK_DIV-1).
  - Quarter index q (0..3) advances on each tick; a slot ends on the tick of q3.
- Data/ACK bit slot:
  - q0: scl=0, SDA set to its new value.
  - q1: scl=1.
  - q2: scl=1; sda_in is sampled on the q2 tick.
  - q3: scl=0.
  - SDA never changes while scl=1, except in START and STOP.
- States, one slot each unless noted:
  - IDLE: on accept, go to START.
  - START: q0 scl=1, sda released; q1 scl=1, sda low; q2/q3 scl=0, sda low. Then ADDR.
  - ADDR (8 slots): {cmd_addr, cmd_rw}, MSB first. Then AACK.
  - AACK: SDA released; sample. sda_in=1 → rsp_nack set, go to STOP. sda_in=0 → WDATA if write, RDATA if read.
  - WDATA (8 slots): cmd_wdata, MSB first. Then WACK.
  - WACK: SDA released; sample; sda_in=1 → rsp_nack set. Then STOP.
  - RDATA (8 slots): SDA released; shift in sda_in MSB first. Then MNACK.
  - MNACK: master releases SDA (NACK, last byte). Then STOP.
  - STOP: q0 scl=0, sda low; q1 scl=1, sda low; q2 scl=1, sda released; q3 hold.
  - On the q3 tick of STOP: rsp_valid=1 for exactly one cycle; state returns to IDLE.
- rsp_rdata updates only when a read completes with address ACK; otherwise it holds its value.
- rsp_nack is cleared on accept, so it reflects only the current transaction.
- Latency from the accept edge to rsp_valid:
  - Full transaction (START + 8 + 1 + 8 + 1 + STOP = 20 slots): 80*CLK_DIV cycles.
  - Address NACK (START + 8 + 1 + STOP = 11 slots): 44*CLK_DIV cycles.
- A new command may be accepted on the first cycle after rsp_valid; no back-to-back accept on the rsp_valid cycle.

Test Plan:
- CLK_DIV=4; write addr=0x50, wdata=0xA5; bench slave ACKs both phases → SDA bits sampled at SCL high are 1010000,0 then 10100101; rsp_valid exactly 320 cycles after accept; rsp_nack=0.
- Read addr=0x50; slave ACKs and drives 0x3C → rsp_rdata=0x3C, rsp_nack=0; master leaves SDA released in the MNACK slot; STOP seen (SDA rises while SCL=1).
- Write addr=0x11; no slave (sda_in=1) → no data slots; rsp_valid at 176 cycles; rsp_nack=1; rsp_rdata unchanged.
- Write; slave ACKs address but NACKs data → rsp_nack=1 at 320 cycles; STOP generated.
- cmd_valid held high with cmd_wdata changing while busy → only the first command executes; cmd_ready=0 until the cycle after rsp_valid; second command then accepted.
- Reset asserted during RDATA bit 3 → next cycle scl_out=1, sda_oe=0, busy=0, cmd_ready=0 while reset is high; no rsp_valid; a fresh write completes normally afterwards.
- Protocol check throughout all tests: SDA never changes while SCL=1 except at START and STOP.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C bus master: START, address+R/W, ACK, one data byte (write or read),
// ACK/NACK, STOP. One command in, one response out, via valid/ready handshake.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       scl_out,
  output logic       sda_oe,
  input  logic       sda_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MNACK, S_STOP
  } state_t;

  localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_qcnt;
  logic [1:0] r_q;
  logic [2:0] r_bit;
  logic       r_rw;
  logic [6:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic [7:0] r_rdata;
  logic       r_nack;

  logic       w_accept;
  logic       w_tick;
  logic       w_slot_end;
  logic       w_sample;
  logic       w_last_bit;
  logic       w_scl_bit;
  logic       w_scl;
  logic       w_sda_oe;
  logic [7:0] w_abyte;

  assign cmd_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_tick     = (r_state != S_IDLE) && (r_qcnt == QMAX);
  assign w_slot_end = w_tick && (r_q == 2'd3);
  assign w_sample   = w_tick && (r_q == 2'd2);
  assign w_last_bit = (r_bit == 3'd7);
  // SCL is high only in the middle two quarters of a data/ACK slot
  assign w_scl_bit  = r_q[0] ^ r_q[1];
  assign w_abyte    = {r_addr, r_rw};

  assign scl_out   = w_scl;
  assign sda_oe    = w_sda_oe;
  assign rsp_nack  = r_nack;
  assign rsp_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state == S_IDLE)) begin
      r_qcnt <= 8'd0;
      r_q    <= 2'd0;
      r_bit  <= 3'd0;
    end else begin
      r_qcnt <= w_tick ? 8'd0 : r_qcnt + 8'd1;
      if (w_tick) r_q <= r_q + 2'd1;
      if (w_slot_end) r_bit <= (w_next != r_state) ? 3'd0 : r_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rw    <= cmd_rw;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_wdata;
    end
    if ((r_state == S_RDATA) && w_sample) r_shift <= {r_shift[6:0], sda_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nack  <= 1'b0;
      r_rdata <= 8'd0;
    end else begin
      if (w_accept) r_nack <= 1'b0;
      else if (((r_state == S_AACK) || (r_state == S_WACK)) && w_sample && sda_in)
        r_nack <= 1'b1;
      // r_shift already holds the last bit: it was sampled on the q2 tick of this slot
      if ((r_state == S_RDATA) && w_slot_end && w_last_bit) r_rdata <= r_shift;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_scl     = 1'b1;
    w_sda_oe  = 1'b0;
    rsp_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_START;
      end
      S_START: begin
        w_scl    = (r_q < 2'd2);
        w_sda_oe = (r_q != 2'd0);
        if (w_slot_end) w_next = S_ADDR;
      end
      S_ADDR: begin
        w_scl    = w_scl_bit;
        w_sda_oe = !w_abyte[3'd7 - r_bit];
        if (w_slot_end && w_last_bit) w_next = S_AACK;
      end
      S_AACK: begin
        w_scl = w_scl_bit;
        if (w_slot_end) begin
          if (r_nack)    w_next = S_STOP;
          else if (r_rw) w_next = S_RDATA;
          else           w_next = S_WDATA;
        end
      end
      S_WDATA: begin
        w_scl    = w_scl_bit;
        w_sda_oe = !r_wdata[3'd7 - r_bit];
        if (w_slot_end && w_last_bit) w_next = S_WACK;
      end
      S_WACK: begin
        w_scl = w_scl_bit;
        if (w_slot_end) w_next = S_STOP;
      end
      S_RDATA: begin
        w_scl = w_scl_bit;
        if (w_slot_end && w_last_bit) w_next = S_MNACK;
      end
      S_MNACK: begin
        w_scl = w_scl_bit;
        if (w_slot_end) w_next = S_STOP;
      end
      S_STOP: begin
        w_scl    = (r_q != 2'd0);
        w_sda_oe = (r_q < 2'd2);
        if (w_slot_end) begin
          rsp_valid = !reset;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: open-drain bus with a small slave model and a
// bus monitor recording START/STOP events and the SDA level at each SCL rising edge.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       scl_out;
  logic       sda_oe;
  logic       sda_line;

  logic       slv_pull = 1'b0;
  logic       s_ack_addr = 1'b1;
  logic       s_ack_data = 1'b1;
  logic [7:0] s_rdata = 8'h00;

  logic       p_scl = 1'b1;
  logic       p_line = 1'b1;
  logic       bits [32];
  int         nbits = 0;
  int         n_start = 0;
  int         n_stop = 0;

  int         n_pass = 0;
  int         n_total = 0;

  assign sda_line = ~(sda_oe | slv_pull);

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .scl_out   (scl_out),
    .sda_oe    (sda_oe),
    .sda_in    (sda_line)
  );

  always #5 clk = ~clk;

  // Slave drive for the bit whose SCL-low phase is starting (1-based bit index after START)
  function automatic logic slave_bit(input int idx);
    logic rd;
    rd = bits[7];
    if (!s_ack_addr) return 1'b0;
    if (idx == 9) return 1'b1;
    if (idx >= 10 && idx <= 17 && rd) return !s_rdata[17 - idx];
    if (idx == 18 && !rd) return s_ack_data;
    return 1'b0;
  endfunction

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] b;
    b = 8'd0;
    for (int i = 0; i < 8; i++) b = {b[6:0], bits[base + i]};
    return b;
  endfunction

  always @(negedge clk) begin
    p_scl  <= scl_out;
    p_line <= sda_line;
    if (reset) begin
      slv_pull <= 1'b0;
    end else begin
      if (p_scl && scl_out && p_line && !sda_line) begin
        n_start <= n_start + 1;
        nbits   <= 0;
      end
      if (p_scl && scl_out && !p_line && sda_line) n_stop <= n_stop + 1;
      if (!p_scl && scl_out && nbits < 32) begin
        bits[nbits] <= sda_line;
        nbits       <= nbits + 1;
      end
      if (p_scl && !scl_out) slv_pull <= slave_bit(nbits + 1);
    end
  end

  task automatic do_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                        output int lat, output logic acc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    acc       = cmd_ready;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      if (rsp_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (scl_out !== 1'b1) $display("FAIL rst_scl: got %b want 1", scl_out); else n_pass++;
    n_total++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready_in_reset: got %b want 0", cmd_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_nack !== 1'b0) $display("FAIL rst_rsp_nack: got %b want 0", rsp_nack); else n_pass++;
    n_total++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", rsp_rdata); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_write();
    int lat; logic acc; int s0; int p0;
    s_ack_addr = 1'b1; s_ack_data = 1'b1;
    s0 = n_start; p0 = n_stop;
    do_cmd(1'b0, 7'h50, 8'hA5, lat, acc);
    n_total++; if (acc !== 1'b1) $display("FAIL wr_accept: got %b want 1", acc); else n_pass++;
    n_total++; if (lat != 320) $display("FAIL wr_latency: got %0d want 320", lat); else n_pass++;
    n_total++; if (rsp_nack !== 1'b0) $display("FAIL wr_nack: got %b want 0", rsp_nack); else n_pass++;
    n_total++; if (get_byte(0) !== 8'hA0) $display("FAIL wr_addr_bits: got %h want a0", get_byte(0)); else n_pass++;
    n_total++; if (bits[8] !== 1'b0) $display("FAIL wr_aack: got %b want 0", bits[8]); else n_pass++;
    n_total++; if (get_byte(9) !== 8'hA5) $display("FAIL wr_data_bits: got %h want a5", get_byte(9)); else n_pass++;
    n_total++; if (nbits != 19) $display("FAIL wr_scl_pulses: got %0d want 19", nbits); else n_pass++;
    n_total++; if (n_start - s0 != 1) $display("FAIL wr_start_events: got %0d want 1", n_start - s0); else n_pass++;
    n_total++; if (n_stop - p0 != 1) $display("FAIL wr_stop_events: got %0d want 1", n_stop - p0); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL wr_valid_pulse: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL wr_ready_after: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_read();
    int lat; logic acc; int s0; int p0;
    s_ack_addr = 1'b1; s_rdata = 8'h3C;
    s0 = n_start; p0 = n_stop;
    do_cmd(1'b1, 7'h50, 8'h00, lat, acc);
    n_total++; if (lat != 320) $display("FAIL rd_latency: got %0d want 320", lat); else n_pass++;
    n_total++; if (rsp_rdata !== 8'h3C) $display("FAIL rd_data: got %h want 3c", rsp_rdata); else n_pass++;
    n_total++; if (rsp_nack !== 1'b0) $display("FAIL rd_nack: got %b want 0", rsp_nack); else n_pass++;
    n_total++; if (get_byte(0) !== 8'hA1) $display("FAIL rd_addr_bits: got %h want a1", get_byte(0)); else n_pass++;
    n_total++; if (bits[17] !== 1'b1) $display("FAIL rd_mnack: got %b want 1", bits[17]); else n_pass++;
    n_total++; if (n_start - s0 != 1) $display("FAIL rd_start_events: got %0d want 1", n_start - s0); else n_pass++;
    n_total++; if (n_stop - p0 != 1) $display("FAIL rd_stop_events: got %0d want 1", n_stop - p0); else n_pass++;
  endtask

  task automatic test_addr_nack();
    int lat; logic acc; int p0;
    s_ack_addr = 1'b0;
    p0 = n_stop;
    do_cmd(1'b0, 7'h11, 8'h77, lat, acc);
    n_total++; if (lat != 176) $display("FAIL an_latency: got %0d want 176", lat); else n_pass++;
    n_total++; if (rsp_nack !== 1'b1) $display("FAIL an_nack: got %b want 1", rsp_nack); else n_pass++;
    n_total++; if (rsp_rdata !== 8'h3C) $display("FAIL an_rdata_hold: got %h want 3c", rsp_rdata); else n_pass++;
    n_total++; if (nbits != 10) $display("FAIL an_scl_pulses: got %0d want 10", nbits); else n_pass++;
    n_total++; if (get_byte(0) !== 8'h22) $display("FAIL an_addr_bits: got %h want 22", get_byte(0)); else n_pass++;
    n_total++; if (n_stop - p0 != 1) $display("FAIL an_stop_events: got %0d want 1", n_stop - p0); else n_pass++;
  endtask

  task automatic test_data_nack();
    int lat; logic acc; int p0;
    s_ack_addr = 1'b1; s_ack_data = 1'b0;
    p0 = n_stop;
    do_cmd(1'b0, 7'h2A, 8'hFF, lat, acc);
    n_total++; if (lat != 320) $display("FAIL dn_latency: got %0d want 320", lat); else n_pass++;
    n_total++; if (rsp_nack !== 1'b1) $display("FAIL dn_nack: got %b want 1", rsp_nack); else n_pass++;
    n_total++; if (bits[17] !== 1'b1) $display("FAIL dn_wack_level: got %b want 1", bits[17]); else n_pass++;
    n_total++; if (n_stop - p0 != 1) $display("FAIL dn_stop_events: got %0d want 1", n_stop - p0); else n_pass++;
    s_ack_data = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n; int viol; logic rdy_at_valid; int s0; int p0;
    s_ack_addr = 1'b1; s_ack_data = 1'b1;
    s0 = n_start; p0 = n_stop;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h50; cmd_wdata = 8'h5A;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL bb_ready_first: got %b want 1", cmd_ready); else n_pass++;
    @(posedge clk);
    n = 0; viol = 0; rdy_at_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      cmd_wdata = 8'hC3 ^ 8'(n);
      if (rsp_valid === 1'b1) begin
        rdy_at_valid = cmd_ready;
        break;
      end
      if (cmd_ready !== 1'b0) viol++;
    end
    n_total++; if (n != 320) $display("FAIL bb_latency1: got %0d want 320", n); else n_pass++;
    n_total++; if (viol != 0) $display("FAIL bb_ready_while_busy: got %0d cycles want 0", viol); else n_pass++;
    n_total++; if (rdy_at_valid !== 1'b0) $display("FAIL bb_ready_on_valid: got %b want 0", rdy_at_valid); else n_pass++;
    n_total++; if (get_byte(9) !== 8'h5A) $display("FAIL bb_data1: got %h want 5a", get_byte(9)); else n_pass++;
    n_total++; if (n_start - s0 != 1 || n_stop - p0 != 1)
      $display("FAIL bb_events1: got start %0d stop %0d want 1 1", n_start - s0, n_stop - p0); else n_pass++;
    cmd_wdata = 8'h96;
    s0 = n_start; p0 = n_stop;
    @(negedge clk);
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL bb_ready_after: got %b want 1", cmd_ready); else n_pass++;
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      n++;
      if (rsp_valid === 1'b1) break;
    end
    n_total++; if (n != 320) $display("FAIL bb_latency2: got %0d want 320", n); else n_pass++;
    n_total++; if (get_byte(9) !== 8'h96) $display("FAIL bb_data2: got %h want 96", get_byte(9)); else n_pass++;
    n_total++; if (n_start - s0 != 1 || n_stop - p0 != 1)
      $display("FAIL bb_events2: got start %0d stop %0d want 1 1", n_start - s0, n_stop - p0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic acc; int rv;
    s_ack_addr = 1'b1; s_rdata = 8'hC5;
    rv = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h50;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rsp_valid === 1'b1) rv++;
      if (nbits == 13) break;
      @(negedge clk);
    end
    n_total++; if (nbits != 13) $display("FAIL rm_reach_bit3: got %0d want 13", nbits); else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (scl_out !== 1'b1) $display("FAIL rm_scl: got %b want 1", scl_out); else n_pass++;
    n_total++; if (sda_oe !== 1'b0) $display("FAIL rm_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL rm_ready_in_reset: got %b want 0", cmd_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b0) rv++;
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    if (rsp_valid !== 1'b0) rv++;
    n_total++; if (rv != 0) $display("FAIL rm_no_rsp: got %0d pulses want 0", rv); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", cmd_ready); else n_pass++;
    do_cmd(1'b0, 7'h3B, 8'h69, lat, acc);
    n_total++; if (lat != 320) $display("FAIL rm_fresh_latency: got %0d want 320", lat); else n_pass++;
    n_total++; if (rsp_nack !== 1'b0) $display("FAIL rm_fresh_nack: got %b want 0", rsp_nack); else n_pass++;
    n_total++; if (get_byte(0) !== 8'h76) $display("FAIL rm_fresh_addr: got %h want 76", get_byte(0)); else n_pass++;
    n_total++; if (get_byte(9) !== 8'h69) $display("FAIL rm_fresh_data: got %h want 69", get_byte(9)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
